ccip_host_responder: RTL

Cycle-accurate CCI-P host-side responder for simulation and loopback benches: it sits at the far end of an AFU's CCI-P port. It accepts read requests on c0Tx and write requests on c1Tx, and drives c0TxAlmFull/c1TxAlmFull backpressure from queue occupancy. After a fixed minimum latency it returns read responses with deterministic data on c0Rx and write acknowledgements on c1Rx. It also flags any request that arrives while its queue is full.

---
 rtl/ccip_host_model_pkg.sv | 90 +++++++++
 rtl/ccip_host_responder_if.sv | 36 +++
 rtl/ccip_resp_fifo.sv | 61 ++++++
 rtl/ccip_host_responder.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/ccip_host_model_pkg.sv
// Types and helpers shared by the CCI-P host responder model.
// Header layouts follow the CCI-P request/response formats bit for bit.
package ccip_host_model_pkg;

    localparam int STAMP_W           = 8;
    localparam int CCIP_CLADDR_WIDTH = 42;
    localparam int CCIP_MDATA_WIDTH  = 16;
    localparam int CCIP_CLDATA_WIDTH = 512;

    typedef logic [CCIP_CLADDR_WIDTH-1:0] t_ccip_clAddr;
    typedef logic [CCIP_MDATA_WIDTH-1:0]  t_ccip_mdata;
    typedef logic [CCIP_CLDATA_WIDTH-1:0] t_ccip_clData;
    typedef logic [STAMP_W-1:0]           t_stamp;

    typedef enum logic [1:0] {
        eVC_VA  = 2'd0,
        eVC_VL0 = 2'd1,
        eVC_VH0 = 2'd2,
        eVC_VH1 = 2'd3
    } t_ccip_vc;

    typedef enum logic [3:0] {
        eRSP_RDLINE = 4'h0,
        eRSP_WRLINE = 4'h1
    } t_ccip_rsp;

    typedef struct packed {
        t_ccip_vc     vc_sel;
        logic [1:0]   rsvd1;
        logic [1:0]   cl_len;
        logic [3:0]   req_type;
        logic [5:0]   rsvd0;
        t_ccip_clAddr address;
        t_ccip_mdata  mdata;
    } t_ccip_c0_ReqMemHdr;

    typedef struct packed {
        logic [5:0]   rsvd2;
        t_ccip_vc     vc_sel;
        logic         sop;
        logic         rsvd1;
        logic [1:0]   cl_len;
        logic [3:0]   req_type;
        logic [5:0]   rsvd0;
        t_ccip_clAddr address;
        t_ccip_mdata  mdata;
    } t_ccip_c1_ReqMemHdr;

    typedef struct packed {
        t_ccip_vc    vc_used;
        logic        rsvd1;
        logic        hit_miss;
        logic [1:0]  rsvd0;
        logic [1:0]  cl_num;
        t_ccip_rsp   resp_type;
        t_ccip_mdata mdata;
    } t_ccip_c0_RspMemHdr;

    typedef struct packed {
        t_ccip_vc    vc_used;
        logic        rsvd1;
        logic        hit_miss;
        logic        format;
        logic        rsvd0;
        logic [1:0]  cl_num;
        t_ccip_rsp   resp_type;
        t_ccip_mdata mdata;
    } t_ccip_c1_RspMemHdr;

    typedef struct packed {
        t_ccip_mdata  mdata;
        t_ccip_clAddr address;
        t_stamp       stamp;
    } t_rd_entry;

    typedef struct packed {
        t_ccip_mdata mdata;
        t_stamp      stamp;
    } t_wr_entry;

    // Each 64-bit lane carries the line address plus its lane index.
    function automatic t_ccip_clData rd_line_data(input t_ccip_clAddr addr);
        t_ccip_clData d;
        for (int i = 0; i < 8; i++) begin
            d[i*64 +: 64] = {22'b0, addr} + 64'(i);
        end
        return d;
    endfunction

endpackage

// File: rtl/ccip_host_responder_if.sv
// CCI-P port bundle between an AFU (master) and the host responder (slave).
interface ccip_host_responder_if;
    import ccip_host_model_pkg::*;

    t_ccip_c0_ReqMemHdr c0Tx_hdr;
    logic               c0Tx_valid;
    t_ccip_c1_ReqMemHdr c1Tx_hdr;
    t_ccip_clData       c1Tx_data;
    logic               c1Tx_valid;
    logic               c0TxAlmFull;
    logic               c1TxAlmFull;
    t_ccip_c0_RspMemHdr c0Rx_hdr;
    t_ccip_clData       c0Rx_data;
    logic               c0Rx_rspValid;
    logic               c0Rx_mmioRdValid;
    logic               c0Rx_mmioWrValid;
    t_ccip_c1_RspMemHdr c1Rx_hdr;
    logic               c1Rx_rspValid;
    logic               overflow_err;
    logic [31:0]        rd_rsp_cnt;
    logic [31:0]        wr_rsp_cnt;

    modport master (
        output c0Tx_hdr, c0Tx_valid, c1Tx_hdr, c1Tx_data, c1Tx_valid,
        input  c0TxAlmFull, c1TxAlmFull, c0Rx_hdr, c0Rx_data, c0Rx_rspValid,
               c0Rx_mmioRdValid, c0Rx_mmioWrValid, c1Rx_hdr, c1Rx_rspValid,
               overflow_err, rd_rsp_cnt, wr_rsp_cnt
    );

    modport slave (
        input  c0Tx_hdr, c0Tx_valid, c1Tx_hdr, c1Tx_data, c1Tx_valid,
        output c0TxAlmFull, c1TxAlmFull, c0Rx_hdr, c0Rx_data, c0Rx_rspValid,
               c0Rx_mmioRdValid, c0Rx_mmioWrValid, c1Rx_hdr, c1Rx_rspValid,
               overflow_err, rd_rsp_cnt, wr_rsp_cnt
    );
endinterface

// File: rtl/ccip_resp_fifo.sv
// Generic synchronous FIFO holding pending requests for one channel.
// Latency: head visible the cycle after push. Backpressure: push into a full queue is ignored unless it pops that cycle.
// count_next exposes post-update occupancy so callers can register threshold flags.
module ccip_resp_fifo #(
    parameter type T        = logic [7:0],
    parameter int  DEPTH    = 64,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  logic        pop,
    input  T            din,
    output T            head,
    output logic [AW:0] count_next,
    output logic        full,
    output logic        empty
);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    T               mem [DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [AW:0]    count_q, count_d;
    logic           push_ok, pop_ok;

    assign full    = (count_q == FULL_CNT);
    assign empty   = (count_q == '0);
    assign push_ok = push && (!full || pop);
    assign pop_ok  = pop && !empty;
    assign head    = mem[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
        if (push_ok && !pop_ok)      count_d = count_q + (AW+1)'(1);
        else if (!push_ok && pop_ok) count_d = count_q - (AW+1)'(1);
    end

    assign count_next = count_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/ccip_host_responder.sv
// Host-side CCI-P responder: returns read lines and write acks after a fixed minimum latency.
// Latency: LATENCY+1 cycles from acceptance to rspValid on an idle queue; one response per channel per cycle.
// Backpressure: registered AlmFull per channel; a push into a full, non-popping queue is dropped and flagged.
module ccip_host_responder
    import ccip_host_model_pkg::*;
#(
    parameter int DEPTH         = 64,
    parameter int ALMFULL_SLACK = 8,
    parameter int LATENCY       = 16
) (
    input  logic                  pClk,
    input  logic                  pck_cp2af_softReset_n,
    ccip_host_responder_if.slave  ccip
);
    localparam int          AW     = $clog2(DEPTH);
    localparam logic [AW:0] AF_THR = (AW+1)'(DEPTH - ALMFULL_SLACK);
    localparam t_stamp      LAT    = STAMP_W'(LATENCY);

    t_stamp             now_q, now_d;
    t_rd_entry          rd_in, rd_head;
    t_wr_entry          wr_in, wr_head;
    logic [AW:0]        rd_cnt_nxt, wr_cnt_nxt;
    logic               rd_full, rd_empty, wr_full, wr_empty;
    logic               rd_pop, wr_pop;
    t_stamp             rd_age, wr_age;

    logic               c0_vld_q, c0_vld_d;
    t_ccip_c0_RspMemHdr c0_hdr_q, c0_hdr_d;
    t_ccip_clData       c0_data_q, c0_data_d;
    logic               c1_vld_q, c1_vld_d;
    t_ccip_c1_RspMemHdr c1_hdr_q, c1_hdr_d;
    logic [31:0]        rd_cnt_q, rd_cnt_d;
    logic [31:0]        wr_cnt_q, wr_cnt_d;
    logic               c0_af_q, c0_af_d;
    logic               c1_af_q, c1_af_d;
    logic               ovf_q, ovf_d;
    logic               unused_tx;

    assign rd_in = '{mdata: ccip.c0Tx_hdr.mdata, address: ccip.c0Tx_hdr.address, stamp: now_q};
    assign wr_in = '{mdata: ccip.c1Tx_hdr.mdata, stamp: now_q};

    ccip_resp_fifo #(.T(t_rd_entry), .DEPTH(DEPTH)) u_rd_fifo (
        .clk        (pClk),
        .rst_n      (pck_cp2af_softReset_n),
        .push       (ccip.c0Tx_valid),
        .pop        (rd_pop),
        .din        (rd_in),
        .head       (rd_head),
        .count_next (rd_cnt_nxt),
        .full       (rd_full),
        .empty      (rd_empty)
    );

    ccip_resp_fifo #(.T(t_wr_entry), .DEPTH(DEPTH)) u_wr_fifo (
        .clk        (pClk),
        .rst_n      (pck_cp2af_softReset_n),
        .push       (ccip.c1Tx_valid),
        .pop        (wr_pop),
        .din        (wr_in),
        .head       (wr_head),
        .count_next (wr_cnt_nxt),
        .full       (wr_full),
        .empty      (wr_empty)
    );

    // Age wraps mod 256; heads never wait long enough for the wrap to alias.
    assign rd_age = now_q - rd_head.stamp;
    assign wr_age = now_q - wr_head.stamp;
    assign rd_pop = !rd_empty && (rd_age >= LAT);
    assign wr_pop = !wr_empty && (wr_age >= LAT);

    always_comb begin
        now_d     = now_q + STAMP_W'(1);
        c0_vld_d  = rd_pop;
        c0_hdr_d  = c0_hdr_q;
        c0_data_d = c0_data_q;
        c1_vld_d  = wr_pop;
        c1_hdr_d  = c1_hdr_q;
        if (rd_pop) begin
            c0_hdr_d           = '0;
            c0_hdr_d.vc_used   = eVC_VL0;
            c0_hdr_d.resp_type = eRSP_RDLINE;
            c0_hdr_d.mdata     = rd_head.mdata;
            c0_data_d          = rd_line_data(rd_head.address);
        end
        if (wr_pop) begin
            c1_hdr_d           = '0;
            c1_hdr_d.vc_used   = eVC_VL0;
            c1_hdr_d.resp_type = eRSP_WRLINE;
            c1_hdr_d.mdata     = wr_head.mdata;
        end
        rd_cnt_d = rd_cnt_q + 32'(rd_pop);
        wr_cnt_d = wr_cnt_q + 32'(wr_pop);
        c0_af_d  = (rd_cnt_nxt >= AF_THR);
        c1_af_d  = (wr_cnt_nxt >= AF_THR);
        ovf_d    = ovf_q
                 | (ccip.c0Tx_valid && rd_full && !rd_pop)
                 | (ccip.c1Tx_valid && wr_full && !wr_pop);
    end

    always_ff @(posedge pClk) begin
        if (!pck_cp2af_softReset_n) begin
            now_q     <= '0;
            c0_vld_q  <= 1'b0;
            c0_hdr_q  <= '0;
            c0_data_q <= '0;
            c1_vld_q  <= 1'b0;
            c1_hdr_q  <= '0;
            rd_cnt_q  <= '0;
            wr_cnt_q  <= '0;
            c0_af_q   <= 1'b0;
            c1_af_q   <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            now_q     <= now_d;
            c0_vld_q  <= c0_vld_d;
            c0_hdr_q  <= c0_hdr_d;
            c0_data_q <= c0_data_d;
            c1_vld_q  <= c1_vld_d;
            c1_hdr_q  <= c1_hdr_d;
            rd_cnt_q  <= rd_cnt_d;
            wr_cnt_q  <= wr_cnt_d;
            c0_af_q   <= c0_af_d;
            c1_af_q   <= c1_af_d;
            ovf_q     <= ovf_d;
        end
    end

    assign ccip.c0TxAlmFull      = c0_af_q;
    assign ccip.c1TxAlmFull      = c1_af_q;
    assign ccip.c0Rx_hdr         = c0_hdr_q;
    assign ccip.c0Rx_data        = c0_data_q;
    assign ccip.c0Rx_rspValid    = c0_vld_q;
    assign ccip.c0Rx_mmioRdValid = 1'b0;
    assign ccip.c0Rx_mmioWrValid = 1'b0;
    assign ccip.c1Rx_hdr         = c1_hdr_q;
    assign ccip.c1Rx_rspValid    = c1_vld_q;
    assign ccip.overflow_err     = ovf_q;
    assign ccip.rd_rsp_cnt       = rd_cnt_q;
    assign ccip.wr_rsp_cnt       = wr_cnt_q;

    // Write payload and most request header fields have no effect on responses.
    assign unused_tx = ^{ccip.c0Tx_hdr, ccip.c1Tx_hdr, ccip.c1Tx_data};

endmodule
